// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is cut into STAGES registered chunks,
// with a per-stage valid/ready handshake that collapses bubbles and holds under backpressure.
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CHUNK = WIDTH / STAGES;
  localparam int unsigned LAST  = STAGES - 1;
  localparam int unsigned MSB   = WIDTH - 1;

  if (WIDTH < 2) begin : g_bad_width
    $error("pipelined_addsub: WIDTH must be >= 2");
  end
  if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_bad_stages
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES");
  end

  // Per-stage state: operands travel skewed with the op, finished chunks accumulate in r_s.
  logic [STAGES-1:0] r_v;
  logic [STAGES-1:0] r_c;
  logic [WIDTH-1:0]  r_a [STAGES];
  logic [WIDTH-1:0]  r_b [STAGES];
  logic [WIDTH-1:0]  r_s [STAGES];
  logic              r_ovf;

  logic [WIDTH-1:0]  w_b_eff;
  logic              w_c0;
  logic [WIDTH-1:0]  w_a_in  [STAGES];
  logic [WIDTH-1:0]  w_b_in  [STAGES];
  logic [WIDTH-1:0]  w_s_in  [STAGES];
  logic [WIDTH-1:0]  w_s_out [STAGES];
  logic [CHUNK:0]    w_part  [STAGES];
  logic [STAGES-1:0] w_c_in;
  logic [STAGES-1:0] w_c_out;
  logic [STAGES-1:0] w_v_in;
  logic [STAGES-1:0] w_load;
  logic              w_all;
  logic              w_ovf;

  // Datapath: each stage resolves its own chunk using the carry captured by the stage before.
  always_comb begin
    w_b_eff    = sub ? ~b : b;
    w_c0       = sub ^ cin;
    w_c_in     = '0;
    w_c_out    = '0;
    w_v_in     = '0;
    w_a_in[0]  = a;
    w_b_in[0]  = w_b_eff;
    w_s_in[0]  = '0;
    w_c_in[0]  = w_c0;
    w_v_in[0]  = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      w_a_in[k] = r_a[k-1];
      w_b_in[k] = r_b[k-1];
      w_s_in[k] = r_s[k-1];
      w_c_in[k] = r_c[k-1];
      w_v_in[k] = r_v[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      w_part[k]  = (CHUNK+1)'(w_a_in[k][k*CHUNK +: CHUNK])
                 + (CHUNK+1)'(w_b_in[k][k*CHUNK +: CHUNK])
                 + (CHUNK+1)'(w_c_in[k]);
      w_s_out[k] = w_s_in[k];
      w_s_out[k][k*CHUNK +: CHUNK] = w_part[k][CHUNK-1:0];
      w_c_out[k] = w_part[k][CHUNK];
    end
    w_ovf = (w_a_in[LAST][MSB] == w_b_in[LAST][MSB]) &&
            (w_s_out[LAST][MSB] != w_a_in[LAST][MSB]);
  end

  // Stage k may load unless it and every stage after it is occupied while the consumer stalls.
  always_comb begin
    w_load = '0;
    w_all  = 1'b1;
    for (int k = 0; k < STAGES; k++) begin
      w_all = 1'b1;
      for (int j = k; j < STAGES; j++) begin
        w_all = w_all & r_v[j];
      end
      w_load[k] = ~w_all | out_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v   <= '0;
      r_c   <= '0;
      r_ovf <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_v[k] <= w_v_in[k];
          r_c[k] <= w_c_out[k];
          r_a[k] <= w_a_in[k];
          r_b[k] <= w_b_in[k];
          r_s[k] <= w_s_out[k];
        end
      end
      if (w_load[LAST]) begin
        r_ovf <= w_ovf;
      end
    end
  end

  assign in_ready  = w_load[0];
  assign out_valid = r_v[LAST];
  assign sum       = r_s[LAST];
  assign cout      = r_c[LAST];
  assign ovf       = r_ovf;

endmodule
